// File: rtl/log_pkg.sv
// Shared constants and helpers for the log-domain datapath (encoder, multipliers, FIR taps).
package log_pkg;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefQp       = 12;
  localparam int unsigned DefLen      = 8;
  localparam int unsigned DefLogWidth = 17;
  localparam int unsigned DefLogFrac  = 12;

  // Integer part lands above the fraction; callers truncate to their log word width.
  function automatic int log_pack(input int int_part, input int frac, input int frac_bits);
    return (int_part << frac_bits) + frac;
  endfunction

endpackage

// File: rtl/leading_one_detect.sv
// Combinational leading-one detector: index of the most significant set bit plus an any-one flag.
module leading_one_detect #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PosW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_mag,
  output logic [PosW-1:0]  o_pos,
  output logic             o_any
);

  always_comb begin
    o_pos = '0;
    o_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_mag[i]) begin
        o_pos = PosW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/log_vec_encoder.sv
// Linear-to-log (Mitchell) encoder that packs LEN converted samples into one vector per handoff.
module log_vec_encoder
  import log_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned QP        = DefQp,
  parameter int unsigned LEN       = DefLen,
  parameter int unsigned LOG_WIDTH = DefLogWidth,
  parameter int unsigned LOG_FRAC  = DefLogFrac
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [LEN*LOG_WIDTH-1:0] o_vec_packed,
  output logic [LEN-1:0]           o_vec_packed_sign,
  output logic [LEN-1:0]           o_vec_packed_valid,
  output logic                     o_valid,
  input  logic                     i_ready
);

  localparam int unsigned CntW = $clog2(LEN + 1);
  localparam int unsigned PosW = $clog2(WIDTH);

  logic [CntW-1:0]               r_acc_cnt, r_wr_cnt, w_acc_cnt_d, w_wr_cnt_d;
  logic                          r_out_valid, w_out_valid_d;
  logic                          r_in_vld;
  logic [WIDTH-1:0]              r_in_data;
  logic                          r_s1_vld, r_s1_sign, r_s1_zero;
  logic [WIDTH-1:0]              r_s1_mag;
  logic [LEN-1:0][LOG_WIDTH-1:0] r_slot_log;
  logic [LEN-1:0]                r_slot_sign, r_slot_nz;
  logic                          w_accept, w_handoff;
  logic [WIDTH-1:0]              w_mag, w_norm;
  logic [PosW-1:0]               w_pos;
  logic                          w_any;
  logic [LOG_FRAC-1:0]           w_frac;
  logic [LOG_WIDTH-1:0]          w_log;

  assign o_ready   = (r_acc_cnt < CntW'(LEN));
  assign w_accept  = i_valid & o_ready;
  assign w_handoff = r_out_valid & i_ready;

  // -2^(WIDTH-1) wraps to itself, which is the correct unsigned magnitude.
  assign w_mag = r_in_data[WIDTH-1] ? (~r_in_data + WIDTH'(1)) : r_in_data;

  leading_one_detect #(
    .WIDTH (WIDTH),
    .PosW  (PosW)
  ) u_lod (
    .i_mag (r_s1_mag),
    .o_pos (w_pos),
    .o_any (w_any)
  );

  assign w_norm = r_s1_mag << (PosW'(WIDTH - 1) - w_pos);
  // Drop the implicit leading one and keep the top LOG_FRAC mantissa bits.
  assign w_frac = LOG_FRAC'(w_norm >> (WIDTH - 1 - LOG_FRAC));
  assign w_log  = w_any ? LOG_WIDTH'(log_pack(int'(w_pos) - int'(QP), int'(w_frac),
                                              int'(LOG_FRAC)))
                        : '0;

  always_comb begin
    w_acc_cnt_d   = r_acc_cnt;
    w_wr_cnt_d    = r_wr_cnt;
    w_out_valid_d = r_out_valid;
    if (w_handoff) begin
      w_acc_cnt_d   = '0;
      w_wr_cnt_d    = '0;
      w_out_valid_d = 1'b0;
    end else begin
      if (w_accept) w_acc_cnt_d = r_acc_cnt + CntW'(1);
      if (r_s1_vld) w_wr_cnt_d = r_wr_cnt + CntW'(1);
      if (r_wr_cnt == CntW'(LEN)) w_out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_in_vld    <= 1'b0;
      r_in_data   <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_mag    <= '0;
    end else begin
      r_acc_cnt   <= w_acc_cnt_d;
      r_wr_cnt    <= w_wr_cnt_d;
      r_out_valid <= w_out_valid_d;
      r_in_vld    <= w_accept;
      if (w_accept) r_in_data <= i_data;
      r_s1_vld <= r_in_vld;
      if (r_in_vld) begin
        r_s1_sign <= r_in_data[WIDTH-1];
        r_s1_mag  <= w_mag;
        r_s1_zero <= (r_in_data == '0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_log  <= '0;
      r_slot_sign <= '0;
      r_slot_nz   <= '0;
    end else begin
      for (int k = 0; k < LEN; k++) begin
        if (r_s1_vld && (r_wr_cnt == CntW'(k))) begin
          r_slot_log[k]  <= r_s1_zero ? '0 : w_log;
          r_slot_sign[k] <= r_s1_sign & ~r_s1_zero;
          r_slot_nz[k]   <= ~r_s1_zero;
        end
      end
    end
  end

  assign o_vec_packed       = r_slot_log;
  assign o_vec_packed_sign  = r_slot_sign;
  assign o_vec_packed_valid = r_slot_nz;
  assign o_valid            = r_out_valid;

endmodule

// File: tb/tb_log_vec_encoder.sv
// Randomized self-checking bench for log_vec_encoder against an arithmetic Mitchell model.
module tb_log_vec_encoder;

  localparam int W   = 16;
  localparam int QP  = 12;
  localparam int LEN = 8;
  localparam int LW  = 17;
  localparam int LF  = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W-1:0]      i_data = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [LEN*LW-1:0] o_vec_packed;
  logic [LEN-1:0]    o_vec_packed_sign;
  logic [LEN-1:0]    o_vec_packed_valid;
  logic              o_valid;
  logic              i_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  samp [LEN];
  logic [LW-1:0] cvec [LEN];

  always #5 clk = ~clk;

  log_vec_encoder dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_data             (i_data),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .o_vec_packed       (o_vec_packed),
    .o_vec_packed_sign  (o_vec_packed_sign),
    .o_vec_packed_valid (o_vec_packed_valid),
    .o_valid            (o_valid),
    .i_ready            (i_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // log2|x| ~= p + (|x|/2^p - 1), scaled to LF fractional bits, truncated.
  function automatic logic [LW-1:0] ref_log(input logic [W-1:0] x);
    int v, mag, p, frac;
    v   = int'($signed(x));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return '0;
    p = 0;
    for (int i = 0; i < W; i++) if (mag >= (1 << i)) p = i;
    frac = ((mag - (1 << p)) * (1 << LF)) / (1 << p);
    return LW'((p - QP) * (1 << LF) + frac);
  endfunction

  task automatic run_frame(input string tag, input bit gapped, input int hold, input bit use_const);
    int n, cyc, k;
    bit acc;
    logic [LEN-1:0] exp_sign, exp_nz;
    logic [LW-1:0]  exp_log;
    n = 0;
    cyc = 0;
    i_ready = (hold == 0);
    while (n < LEN && cyc < 100) begin
      i_valid = gapped ? ((cyc % 2) == 0) : 1'b1;
      i_data  = samp[n];
      acc = i_valid && o_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) n++;
    end
    i_valid = 1'b0;
    i_data  = W'($urandom);
    check({tag, "_accepted"}, 64'(n), 64'(LEN));
    check({tag, "_rdy_full"}, 64'(o_ready), 64'd0);
    check({tag, "_ov_early"}, 64'(o_valid), 64'd0);
    k = 0;
    while (!o_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_ov_latency"}, 64'(k), 64'd3);
    if (hold > 0) begin
      i_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        i_data = W'($urandom);
        check({tag, "_bp_rdy"}, 64'(o_ready), 64'd0);
        check({tag, "_bp_ov"}, 64'(o_valid), 64'd1);
      end
      i_valid = 1'b0;
    end
    for (int s = 0; s < LEN; s++) begin
      exp_log     = use_const ? cvec[s] : ref_log(samp[s]);
      exp_sign[s] = ($signed(samp[s]) < 0);
      exp_nz[s]   = (samp[s] != '0);
      check($sformatf("%s_slot%0d", tag, s), 64'(o_vec_packed[s*LW +: LW]), 64'(exp_log));
    end
    check({tag, "_sign"}, 64'(o_vec_packed_sign), 64'(exp_sign));
    check({tag, "_valid"}, 64'(o_vec_packed_valid), 64'(exp_nz));
    i_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ho_ov"}, 64'(o_valid), 64'd0);
    check({tag, "_ho_rdy"}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    repeat (3) begin
      i_data  = W'($urandom);
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
      @(posedge clk); #1;
      check("rst_rdy", 64'(o_ready), 64'd1);
      check("rst_ov", 64'(o_valid), 64'd0);
      check("rst_vec", 64'(|o_vec_packed), 64'd0);
      check("rst_sign", 64'(o_vec_packed_sign), 64'd0);
      check("rst_valid", 64'(o_vec_packed_valid), 64'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    samp[0] = 16'h1000; cvec[0] = 17'h00000;
    samp[1] = 16'h2000; cvec[1] = 17'h01000;
    samp[2] = 16'h1800; cvec[2] = 17'h00800;
    samp[3] = 16'h0001; cvec[3] = 17'h14000;
    samp[4] = 16'h0000; cvec[4] = 17'h00000;
    samp[5] = 16'hF000; cvec[5] = 17'h00000;
    samp[6] = 16'h8000; cvec[6] = 17'h03000;
    samp[7] = 16'h0800; cvec[7] = 17'h1F000;
    run_frame("pow", 1'b0, 0, 1'b1);
    check("pow_sign_lit", 64'(o_vec_packed_sign), 64'h60);
    check("pow_valid_lit", 64'(o_vec_packed_valid), 64'hEF);

    for (int i = 0; i < LEN; i++) samp[i] = W'($urandom);
    run_frame("bp", 1'b0, 20, 1'b0);

    for (int i = 0; i < LEN; i++) samp[i] = W'($urandom);
    run_frame("gap", 1'b1, 0, 1'b0);

    i_ready = 1'b1;
    i_valid = 1'b1;
    repeat (5) begin
      i_data = W'($urandom_range(1, 65535));
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 64'(o_valid), 64'd0);
    check("mid_rst_rdy", 64'(o_ready), 64'd1);
    check("mid_rst_vec", 64'(|o_vec_packed), 64'd0);
    check("mid_rst_sign", 64'(o_vec_packed_sign), 64'd0);
    check("mid_rst_valid", 64'(o_vec_packed_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < LEN; i++) samp[i] = W'($urandom);
    run_frame("post_rst", 1'b0, 0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < LEN; i++) begin
        case ($urandom_range(0, 5))
          0:       samp[i] = 16'h0000;
          1:       samp[i] = 16'h8000;
          default: samp[i] = W'($urandom);
        endcase
      end
      run_frame($sformatf("rnd%0d", f), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
